// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: instruction constants and the
// fetch state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline boundary register: valid, PC, PC+4 and instruction.
// Flush (or reset) inserts a bubble, load captures new contents, otherwise hold.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc4_i,
    input  logic [31:0] inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic [31:0] inst_o
);

    logic        valid_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc4_reg;
    logic [31:0] inst_reg;

    // Flush wins over load; the bubble keeps the old PC fields so only
    // valid/inst mark it as empty.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_reg <= 1'b0;
            pc_reg    <= 32'h0;
            pc4_reg   <= 32'h0;
            inst_reg  <= NOP_INST;
        end else if (flush_i) begin
            valid_reg <= 1'b0;
            inst_reg  <= NOP_INST;
        end else if (load_i) begin
            valid_reg <= 1'b1;
            pc_reg    <= pc_i;
            pc4_reg   <= pc4_i;
            inst_reg  <= inst_i;
        end
    end

    assign valid_o = valid_reg;
    assign pc_o    = pc_reg;
    assign pc4_o   = pc4_reg;
    assign inst_o  = inst_reg;

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch stage. Drives the inst_mem word address from the
// PC, captures the returned instruction into IF/ID, and handles stall,
// redirect-with-flush and halt on EBREAK.
// Optional feature: define FETCH_MISALIGN_CHK_EN to refuse misaligned
// redirects (sticky misalign_o, fetch halts); otherwise the low target bits
// are simply cleared.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_data_i,
    output logic              if_id_valid_o,
    output logic [31:0]       if_id_pc_o,
    output logic [31:0]       if_id_pc4_o,
    output logic [31:0]       if_id_inst_o,
    output logic              halted_o,
    output logic              misalign_o
);

    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;
    logic [31:0]  pc_plus4;
    fetch_state_e state_reg;
    fetch_state_e state_next;
    logic         misalign_reg;
    logic         misalign_set;
    logic         ifid_load;
    logic         ifid_flush;
    logic         redirect_ok;
    logic [31:0]  redirect_tgt;

    assign pc_plus4    = pc_reg + 32'd4;
    // Address depends on the PC register alone, so no combinational path
    // from the control inputs reaches inst_mem.
    assign imem_addr_o = pc_reg[ADDR_W+1:2];

`ifdef FETCH_MISALIGN_CHK_EN
    assign redirect_ok  = (redirect_pc_i[1:0] == 2'b00);
    assign redirect_tgt = redirect_pc_i;
`else
    assign redirect_ok  = 1'b1;
    assign redirect_tgt = redirect_pc_i & ~32'h3;
`endif

    // Next-PC mux and state transition; redirect beats stall beats advance.
    always_comb begin
        pc_next      = pc_reg;
        state_next   = state_reg;
        ifid_load    = 1'b0;
        ifid_flush   = 1'b0;
        misalign_set = 1'b0;
        case (state_reg)
            BOOT: begin
                ifid_flush = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (redirect_i) begin
                    ifid_flush = 1'b1;
                    if (redirect_ok) begin
                        pc_next = redirect_tgt;
                    end else begin
                        misalign_set = 1'b1;
                        state_next   = HALT;
                    end
                end else if (!stall_i) begin
                    ifid_load = 1'b1;
                    pc_next   = pc_plus4;
                    if (imem_data_i == EBREAK_INST) begin
                        state_next = HALT;
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
                if (redirect_i) begin
                    if (redirect_ok) begin
                        pc_next    = redirect_tgt;
                        state_next = RUN;
                    end else begin
                        misalign_set = 1'b1;
                    end
                end
            end
            default: begin
                ifid_flush = 1'b1;
                state_next = BOOT;
            end
        endcase
    end

    // PC, fetch state and sticky misalign flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_reg       <= RESET_PC;
            state_reg    <= BOOT;
            misalign_reg <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            state_reg <= state_next;
            if (misalign_set) begin
                misalign_reg <= 1'b1;
            end
        end
    end

    assign halted_o   = (state_reg == HALT);
    assign misalign_o = misalign_reg;

    if_id_reg u_if_id_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (ifid_load),
        .flush_i (ifid_flush),
        .pc_i    (pc_reg),
        .pc4_i   (pc_plus4),
        .inst_i  (imem_data_i),
        .valid_o (if_id_valid_o),
        .pc_o    (if_id_pc_o),
        .pc4_o   (if_id_pc4_o),
        .inst_o  (if_id_inst_o)
    );

endmodule
